// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, priced selection, dispenser
// request/acknowledge handshake with timeout refund, and unit-by-unit change.
module vend_sequencer #(
    parameter int CREDIT_W = 4,
    parameter int PRICE    = 3,
    parameter int TIMEOUT  = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin,
    input  logic                sel_valid,
    input  logic [2:0]          sel_code,
    input  logic                cancel,
    output logic                disp_req,
    output logic [2:0]          disp_code,
    input  logic                disp_ack,
    output logic                change_pulse,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                err
);

    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CREDIT_W-1:0] MAX_CREDIT = '1;
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_DISPENSE,
        ST_CHANGE
    } state_t;

    state_t               state;
    logic [TIMER_W-1:0]   timer;
    logic                 coin_ok;
    logic [CREDIT_W-1:0]  credit_inc;
    logic [CREDIT_W:0]    refund_sum;
    logic [CREDIT_W-1:0]  refund;

    // A coin is accepted only while the register has headroom; a timeout
    // refund saturates at the maximum and silently drops the excess.
    assign coin_ok    = coin && (credit != MAX_CREDIT);
    assign credit_inc = credit + {{(CREDIT_W-1){1'b0}}, coin_ok};
    assign refund_sum = {1'b0, credit} + (CREDIT_W+1)'(PRICE);
    assign refund     = (refund_sum > {1'b0, MAX_CREDIT}) ? MAX_CREDIT
                                                          : refund_sum[CREDIT_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            credit       <= '0;
            disp_req     <= 1'b0;
            disp_code    <= '0;
            change_pulse <= 1'b0;
            busy         <= 1'b0;
            coin_reject  <= 1'b0;
            err          <= 1'b0;
        end else begin
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            err          <= 1'b0;
            case (state)
                ST_IDLE, ST_CREDIT: begin
                    coin_reject <= coin && !coin_ok;
                    // Cancel outranks selection; the affordability test uses the pre-coin credit.
                    if (cancel && state == ST_CREDIT) begin
                        credit <= credit_inc;
                        state  <= ST_CHANGE;
                        busy   <= 1'b1;
                    end else if (sel_valid && credit >= PRICE_C) begin
                        disp_code <= sel_code;
                        credit    <= credit_inc - PRICE_C;
                        timer     <= '0;
                        disp_req  <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ST_DISPENSE;
                    end else begin
                        err    <= sel_valid;
                        credit <= credit_inc;
                        state  <= (credit_inc == '0) ? ST_IDLE : ST_CREDIT;
                    end
                end
                ST_DISPENSE: begin
                    coin_reject <= coin;
                    if (disp_ack) begin
                        disp_req <= 1'b0;
                        if (credit != '0) begin
                            state <= ST_CHANGE;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (timer == TIMER_LAST) begin
                        disp_req <= 1'b0;
                        err      <= 1'b1;
                        credit   <= refund;
                        state    <= ST_CHANGE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_CHANGE: begin
                    coin_reject <= coin;
                    if (credit != '0) begin
                        change_pulse <= 1'b1;
                        credit       <= credit - 1'b1;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_sequencer.sv
// Self-checking bench for vend_sequencer: directed vector table, hand-written
// multi-cycle sequences, and random traffic against a transaction-level model.
module tb_vend_sequencer;

    localparam int MAX     = 15;
    localparam int PRICE   = 3;
    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin = 1'b0;
    logic       sel_valid = 1'b0;
    logic [2:0] sel_code = '0;
    logic       cancel = 1'b0;
    logic       disp_ack = 1'b0;
    logic       disp_req;
    logic [2:0] disp_code;
    logic       change_pulse;
    logic [3:0] credit;
    logic       busy;
    logic       coin_reject;
    logic       err;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] credit;
        logic       req;
        logic [2:0] code;
        logic       pulse;
        logic       busy;
        logic       rej;
        logic       err;
    } out_t;

    typedef struct {
        logic       rst;
        logic       coin;
        logic       sel;
        logic [2:0] code;
        logic       cancel;
        logic       ack;
        out_t       exp;
    } vec_t;

    vec_t vecs[$];

    // Transaction-level reference state
    int m_credit;
    int m_code;
    int m_age;
    bit m_vending;
    bit m_paying;
    bit m_req;
    bit m_pulse;
    bit m_rej;
    bit m_err;

    vend_sequencer #(.CREDIT_W(4), .PRICE(PRICE), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .coin(coin),
        .sel_valid(sel_valid),
        .sel_code(sel_code),
        .cancel(cancel),
        .disp_req(disp_req),
        .disp_code(disp_code),
        .disp_ack(disp_ack),
        .change_pulse(change_pulse),
        .credit(credit),
        .busy(busy),
        .coin_reject(coin_reject),
        .err(err)
    );

    always #5 clk = ~clk;

    function automatic out_t mkOut(input int cr, input bit rq, input int cd, input bit p,
                                   input bit b, input bit rj, input bit e);
        out_t o;
        o.credit = 4'(cr);
        o.req    = rq;
        o.code   = 3'(cd);
        o.pulse  = p;
        o.busy   = b;
        o.rej    = rj;
        o.err    = e;
        return o;
    endfunction

    function automatic out_t actualOut();
        return mkOut(int'(credit), disp_req, int'(disp_code), change_pulse, busy, coin_reject, err);
    endfunction

    task automatic addVec(input bit r, input bit c, input bit s, input int cd, input bit ca,
                          input bit a, input int ecr, input bit erq, input int ecd,
                          input bit ep, input bit eb, input bit erj, input bit ee);
        vec_t v;
        v.rst = r; v.coin = c; v.sel = s; v.code = 3'(cd); v.cancel = ca; v.ack = a;
        v.exp = mkOut(ecr, erq, ecd, ep, eb, erj, ee);
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs, let the edge happen, then settle before sampling.
    task automatic applyStimulus(input bit r, input bit c, input bit s, input int cd,
                                 input bit ca, input bit a);
        rst = r; coin = c; sel_valid = s; sel_code = 3'(cd); cancel = ca; disp_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0);
    endtask

    task automatic checkOutput(input string name, input out_t exp);
        out_t act;
        act = actualOut();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got cr=%0d req=%0b code=%0d pulse=%0b busy=%0b rej=%0b err=%0b, want cr=%0d req=%0b code=%0d pulse=%0b busy=%0b rej=%0b err=%0b",
                     name, act.credit, act.req, act.code, act.pulse, act.busy, act.rej, act.err,
                     exp.credit, exp.req, exp.code, exp.pulse, exp.busy, exp.rej, exp.err);
        end
    endtask

    task automatic checkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Reference model expressed as customer-visible rules: credit as an integer,
    // a vend in progress with its age, and a refund being paid out unit by unit.
    task automatic modelStep(input bit r, input bit c, input bit s, input int cd,
                             input bit ca, input bit a);
        bit accepted;
        m_pulse = 0; m_rej = 0; m_err = 0;
        if (r) begin
            m_credit = 0; m_code = 0; m_age = 0;
            m_vending = 0; m_paying = 0; m_req = 0;
        end else if (m_vending) begin
            m_rej = c;
            if (a) begin
                m_req = 0; m_vending = 0;
                m_paying = (m_credit > 0);
            end else if (m_age == TIMEOUT - 1) begin
                m_req = 0; m_vending = 0; m_paying = 1; m_err = 1;
                m_credit = (m_credit + PRICE > MAX) ? MAX : m_credit + PRICE;
            end else begin
                m_age++;
            end
        end else if (m_paying) begin
            m_rej = c;
            if (m_credit > 0) begin
                m_pulse = 1;
                m_credit--;
            end else begin
                m_paying = 0;
            end
        end else begin
            accepted = c && (m_credit < MAX);
            m_rej = c && !accepted;
            if (ca && m_credit > 0) begin
                m_credit += int'(accepted);
                m_paying = 1;
            end else if (s && m_credit >= PRICE) begin
                m_code = cd;
                m_credit = m_credit - PRICE + int'(accepted);
                m_vending = 1; m_req = 1; m_age = 0;
            end else begin
                m_err = s;
                m_credit += int'(accepted);
            end
        end
    endtask

    initial begin
        int cnt;
        int guard;
        bit r, c, s, ca, a;
        int cd;

        // Basic vend with exact credit
        addVec(1,0,0,0,0,0, 0,0,0,0,0,0,0);
        addVec(0,1,0,0,0,0, 1,0,0,0,0,0,0);
        addVec(0,1,0,0,0,0, 2,0,0,0,0,0,0);
        addVec(0,1,0,0,0,0, 3,0,0,0,0,0,0);
        addVec(0,0,1,5,0,0, 0,1,5,0,1,0,0);
        addVec(0,0,0,0,0,0, 0,1,5,0,1,0,0);
        addVec(0,0,0,0,0,0, 0,1,5,0,1,0,0);
        addVec(0,0,0,0,0,0, 0,1,5,0,1,0,0);
        addVec(0,0,0,0,0,1, 0,0,5,0,0,0,0);
        addVec(0,0,0,0,0,0, 0,0,5,0,0,0,0);
        addVec(0,0,0,0,1,0, 0,0,5,0,0,0,0);
        addVec(0,0,0,0,0,1, 0,0,5,0,0,0,0);
        // Vend with change
        for (int i = 1; i <= 5; i++) addVec(0,1,0,0,0,0, i,0,5,0,0,0,0);
        addVec(0,0,1,2,0,0, 2,1,2,0,1,0,0);
        addVec(0,0,0,0,0,1, 2,0,2,0,1,0,0);
        addVec(0,0,0,0,0,0, 1,0,2,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,2,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,2,0,0,0,0);
        // Insufficient credit then cancel
        addVec(0,1,0,0,0,0, 1,0,2,0,0,0,0);
        addVec(0,1,0,0,0,0, 2,0,2,0,0,0,0);
        addVec(0,0,1,3,0,0, 2,0,2,0,0,0,1);
        addVec(0,0,0,0,0,0, 2,0,2,0,0,0,0);
        addVec(0,0,0,0,1,0, 2,0,2,0,1,0,0);
        addVec(0,0,0,0,0,0, 1,0,2,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,2,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,2,0,0,0,0);
        // Cancel beats a same-cycle selection
        for (int i = 1; i <= 3; i++) addVec(0,1,0,0,0,0, i,0,2,0,0,0,0);
        addVec(0,0,1,7,1,0, 3,0,2,0,1,0,0);
        addVec(0,0,0,0,0,0, 2,0,2,1,1,0,0);
        addVec(0,0,0,0,0,0, 1,0,2,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,2,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,2,0,0,0,0);
        // Selection with a same-cycle coin, coin and requests ignored while dispensing
        for (int i = 1; i <= 3; i++) addVec(0,1,0,0,0,0, i,0,2,0,0,0,0);
        addVec(0,1,1,4,0,0, 1,1,4,0,1,0,0);
        addVec(0,1,0,0,0,0, 1,1,4,0,1,1,0);
        addVec(0,0,1,6,1,0, 1,1,4,0,1,0,0);
        addVec(0,0,0,0,0,1, 1,0,4,0,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,4,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,4,0,0,0,0);
        // Short selection with coin, then a coin rejected during change
        addVec(0,1,0,0,0,0, 1,0,4,0,0,0,0);
        addVec(0,1,1,1,0,0, 2,0,4,0,0,0,1);
        addVec(0,0,0,0,1,0, 2,0,4,0,1,0,0);
        addVec(0,1,0,0,0,0, 1,0,4,1,1,1,0);
        addVec(0,0,0,0,0,0, 0,0,4,1,1,0,0);
        addVec(0,0,0,0,0,0, 0,0,4,0,0,0,0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].coin, vecs[i].sel, int'(vecs[i].code),
                          vecs[i].cancel, vecs[i].ack);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Dispenser never answers: request held for the full timeout, then refund
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0);
        cnt = 0;
        guard = 0;
        while (disp_req === 1'b1 && guard < 40) begin
            cnt++;
            guard++;
            idleCycle();
        end
        checkInt("timeout_req_cycles", cnt, TIMEOUT);
        checkOutput("timeout_refund", mkOut(3, 0, 1, 0, 1, 0, 1));
        cnt = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 20) begin
            idleCycle();
            if (change_pulse === 1'b1) cnt++;
            guard++;
        end
        checkInt("timeout_change_pulses", cnt, 3);
        checkOutput("timeout_done", mkOut(0, 0, 1, 0, 0, 0, 0));

        // Credit saturation and a full refund
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("sat_full", mkOut(15, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 1, 0, 0, 0, 0);
        checkOutput("sat_reject", mkOut(15, 0, 0, 0, 0, 1, 0));
        idleCycle();
        checkOutput("sat_reject_oneshot", mkOut(15, 0, 0, 0, 0, 0, 0));
        applyStimulus(0, 0, 0, 0, 1, 0);
        cnt = 0;
        guard = 0;
        while (busy === 1'b1 && guard < 40) begin
            idleCycle();
            if (change_pulse === 1'b1) cnt++;
            guard++;
        end
        checkInt("sat_refund_pulses", cnt, 15);

        // Reset in the middle of a vend discards credit without paying change
        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) applyStimulus(0, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 6, 0, 0);
        checkOutput("mid_vend", mkOut(4, 1, 6, 0, 1, 0, 0));
        idleCycle();
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("mid_vend_reset", mkOut(0, 0, 0, 0, 0, 0, 0));
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            idleCycle();
            if (change_pulse === 1'b1 || busy === 1'b1) cnt++;
        end
        checkInt("post_reset_quiet", cnt, 0);

        // Random traffic against the reference model
        modelStep(1, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0);
        checkOutput("rand_reset", mkOut(m_credit, m_req, m_code, m_pulse,
                                         m_vending || m_paying, m_rej, m_err));
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            c  = ($urandom_range(0, 9) < 4);
            s  = ($urandom_range(0, 9) == 0);
            cd = int'($urandom_range(0, 7));
            ca = ($urandom_range(0, 19) == 0);
            a  = ($urandom_range(0, 24) == 0);
            modelStep(r, c, s, cd, ca, a);
            applyStimulus(r, c, s, cd, ca, a);
            checkOutput($sformatf("rand%0d", i), mkOut(m_credit, m_req, m_code, m_pulse,
                                                       m_vending || m_paying, m_rej, m_err));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
